// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle for mem_port_arbiter (fetch, load/store, memory array).
// Latency: none; wires only.
// Backpressure: requesters hold req/addr/data until their gnt is seen.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  // Load/store port
  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  // Single-port memory array
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  // Arbiter side: consumes requests and read data, drives grants and the memory port.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Core/memory side: drives requests and read data, observes grants and the memory port.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between fetch and load/store; optional ARB_STARVE_GUARD_EN bounds fetch starvation.
// Latency: grant combinational in the request cycle; read data/rvalid one cycle after the grant, fully pipelined.
// Backpressure: data wins ties, the loser sees gnt=0 and holds its request; guard build forces fetch after MAX_WAIT denials.
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Parameter sanity: memory port is byte-enabled and the guard needs a non-zero window.
  if ((DATA_W % 8) != 0) begin : g_bad_data_w
    $error("mem_port_arbiter: DATA_W must be a multiple of 8");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_port_arbiter: MAX_WAIT must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic force_fetch;
  logic d_win;
  logic if_win;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Fetch has been denied MAX_WAIT cycles in a row: it takes the port this cycle.
  always_comb begin
    force_fetch = bus.if_req && (wait_cnt_q == CNT_MAX);
  end

  // Count consecutive fetch denials, saturating; any grant or dropped request restarts the window.
  always_comb begin
    wait_cnt_d = '0;
    if (bus.if_req && !if_win) begin
      wait_cnt_d = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Denial counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Without the guard, data priority is absolute.
  always_comb begin
    force_fetch = 1'b0;
  end
`endif

  // Pick one winner; grants are held low throughout reset so nothing reaches the array.
  always_comb begin
    d_win  = rst && bus.d_req && !force_fetch;
    if_win = rst && bus.if_req && !d_win;
  end

  assign bus.d_gnt  = d_win;
  assign bus.if_gnt = if_win;

  // ---------------------------------------------------------------------------
  // Memory port mux: mirrors whichever requester won
  // ---------------------------------------------------------------------------
  logic                  mem_en_c;
  logic                  mem_we_c;
  logic [DATA_W/8-1:0]   mem_be_c;
  logic [ADDR_W-1:0]     mem_addr_c;
  logic [DATA_W-1:0]     mem_wdata_c;

  // Fetch is always a full-word read; data carries its own strobe, enables and write data.
  always_comb begin
    mem_en_c    = d_win || if_win;
    mem_we_c    = 1'b0;
    mem_be_c    = '1;
    mem_addr_c  = bus.if_addr;
    mem_wdata_c = '0;
    if (d_win) begin
      mem_we_c    = bus.d_we;
      mem_be_c    = bus.d_be;
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
    end
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_be    = mem_be_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

  // ---------------------------------------------------------------------------
  // Response tracker: one read in flight per cycle, owner remembered for routing
  // ---------------------------------------------------------------------------
  logic rd_issue;
  logic rsp_valid_q;
  logic rsp_valid_d;
  logic rsp_owner_q;
  logic rsp_owner_d;

  // A read issued now returns next cycle; stores never produce a response.
  always_comb begin
    rd_issue    = mem_en_c && !mem_we_c;
    rsp_valid_d = rd_issue;
    rsp_owner_d = rsp_owner_q;
    if (rd_issue) begin
      rsp_owner_d = d_win ? OWN_DATA : OWN_FETCH;
    end
  end

  // Tracker registers; async reset drops any read that was in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= OWN_FETCH;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Read data fans out to both owners unregistered; each side trusts only its own rvalid.
  assign bus.if_rvalid = rsp_valid_q && (rsp_owner_q == OWN_FETCH);
  assign bus.d_rvalid  = rsp_valid_q && (rsp_owner_q == OWN_DATA);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst)
    !(bus.if_gnt && bus.d_gnt));

  a_en_matches_gnt: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_en == (bus.if_gnt || bus.d_gnt));

  a_read_returns: assert property (@(posedge clk) disable iff (!rst)
    (bus.mem_en && !bus.mem_we) |=> (bus.if_rvalid || bus.d_rvalid));

  a_store_silent: assert property (@(posedge clk) disable iff (!rst)
    (bus.mem_en && bus.mem_we) |=> !(bus.if_rvalid || bus.d_rvalid));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, scoreboard queue, forked response monitor.
// Latency: checks grants in the issue cycle and responses exactly one cycle later.
// Backpressure: requesters hold their request until granted; guard behaviour follows ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam logic OWN_F  = 1'b0;
  localparam logic OWN_D  = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
  localparam logic GUARD  = 1'b1;
`else
  localparam logic GUARD  = 1'b0;
`endif

  typedef struct {
    logic              owner;
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  logic [DATA_W-1:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory array model: write on the grant edge, read data one cycle later.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = 32'h6C6C6548;
    mem[1] = 32'h6F77206F;
    mem[2] = 32'h21646C72;
    mem[3] = 32'h2C657942;
    mem[5] = 32'hA5A50005;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_en) begin
        if (bus.mem_we) begin
          for (int b = 0; b < DATA_W/8; b++)
            if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        end else begin
          bus.mem_rdata <= mem[bus.mem_addr];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard whenever a response is due or the DUT presents one.
  task automatic monitor();
    exp_t e;
    logic have;
    logic got;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      have = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      got  = bus.if_rvalid || bus.d_rvalid;
      if (have || got) begin
        chk("rsp_present", got, have);
        if (have) begin
          e = sb_q.pop_front();
          if (got) begin
            chk("rsp_d_rvalid", bus.d_rvalid, e.owner);
            chk("rsp_if_rvalid", bus.if_rvalid, !e.owner);
            chk("rsp_data", e.owner ? bus.d_rdata : bus.if_rdata, e.data);
          end
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [ADDR_W-1:0] ia,
                       input logic dr, input logic dwe, input logic [3:0] dbe,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dwd);
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = dbe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
  endtask

  task automatic chk_gnt(input string tag, input logic ei, input logic ed);
    @(negedge clk);
    chk({tag, ".if_gnt"}, bus.if_gnt, ei);
    chk({tag, ".d_gnt"},  bus.d_gnt,  ed);
    chk({tag, ".mem_en"}, bus.mem_en, ei | ed);
    if (ei) begin
      chk({tag, ".fetch_we"}, bus.mem_we, 1'b0);
      chk({tag, ".fetch_be"}, bus.mem_be, 4'hF);
    end
  endtask

  task automatic expect_rsp(input logic owner, input logic [DATA_W-1:0] data);
    sb_q.push_back('{owner: owner, data: data, due: cyc + 1});
  endtask

  initial begin
    logic fg;
    rst = 1'b0;
    drive(1'b1, 8'd1, 1'b1, 1'b0, 4'hF, 8'd0, '0);
    fork
      monitor();
    join_none

    // Reset held with both requests pending: everything quiet.
    @(negedge clk);
    chk("rst.mem_en",    bus.mem_en,    1'b0);
    chk("rst.if_gnt",    bus.if_gnt,    1'b0);
    chk("rst.d_gnt",     bus.d_gnt,     1'b0);
    chk("rst.if_rvalid", bus.if_rvalid, 1'b0);
    chk("rst.d_rvalid",  bus.d_rvalid,  1'b0);

    // Release: data wins immediately.
    next_cycle();
    rst = 1'b1;
    chk_gnt("rel", 1'b0, 1'b1);
    expect_rsp(OWN_D, 32'h6C6C6548);

    // Fetch-only stream, addr 0..3.
    for (int i = 0; i < 4; i++) begin
      logic [DATA_W-1:0] words [4];
      words[0] = 32'h6C6C6548; words[1] = 32'h6F77206F;
      words[2] = 32'h21646C72; words[3] = 32'h2C657942;
      next_cycle();
      drive(1'b1, ADDR_W'(i), 1'b0, 1'b0, 4'h0, 8'd0, '0);
      chk_gnt("fetch", 1'b1, 1'b0);
      expect_rsp(OWN_F, words[i]);
    end

    // Collision: load addr 3 beats fetch addr 5, fetch follows next cycle.
    next_cycle();
    drive(1'b1, 8'd5, 1'b1, 1'b0, 4'hF, 8'd3, '0);
    chk_gnt("coll", 1'b0, 1'b1);
    expect_rsp(OWN_D, 32'h2C657942);
    next_cycle();
    drive(1'b1, 8'd5, 1'b0, 1'b0, 4'h0, 8'd0, '0);
    chk_gnt("coll2", 1'b1, 1'b0);
    expect_rsp(OWN_F, 32'hA5A50005);

    // Partial store to addr 2, then read back.
    next_cycle();
    drive(1'b0, 8'd0, 1'b1, 1'b1, 4'b0011, 8'd2, 32'hDEADBEEF);
    chk_gnt("store", 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 8'd0, 1'b1, 1'b0, 4'hF, 8'd2, '0);
    chk_gnt("ld_after_st", 1'b0, 1'b1);
    expect_rsp(OWN_D, 32'h2164BEEF);

    // Idle: both grants low, counter back to zero.
    next_cycle();
    drive(1'b0, 8'd0, 1'b0, 1'b0, 4'h0, 8'd0, '0);
    chk_gnt("idle", 1'b0, 1'b0);

    // Continuous data pressure with fetch pending for 20 cycles.
    for (int k = 0; k < 20; k++) begin
      next_cycle();
      drive(1'b1, 8'd0, 1'b1, 1'b0, 4'hF, 8'd1, '0);
      fg = GUARD && ((k % (MAX_WAIT + 1)) == MAX_WAIT);
      chk_gnt("starve", fg, !fg);
      if (fg) expect_rsp(OWN_F, 32'h6C6C6548);
      else    expect_rsp(OWN_D, 32'h6F77206F);
    end

    // Load granted, reset asserted before its return edge: no response may appear.
    next_cycle();
    drive(1'b0, 8'd0, 1'b1, 1'b0, 4'hF, 8'd3, '0);
    chk_gnt("inflight", 1'b0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 4'h0, 8'd0, '0);
    @(negedge clk);
    chk("inflight.rst_d_rvalid", bus.d_rvalid, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("inflight.post_d_rvalid", bus.d_rvalid, 1'b0);
    chk("inflight.post_if_rvalid", bus.if_rvalid, 1'b0);

    // Drain: every expected response must have been seen.
    repeat (3) next_cycle();
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the processor's single-port 256×32 word memory between the instruction-fetch path and the load/store path. Issues at most one memory access per cycle, routes one-cycle-latency read data back to the owner, and gives data accesses priority over fetch. A wait counter bounds fetch starvation. Sits between the `RISC_V` core's fetch/LSU ports and the memory array.

## Interface
- `ADDR_W`, default 8: word-address width (256 words).
- `DATA_W`, default 32: data width; byte enables are `DATA_W/8` bits.
- `MAX_WAIT`, default 4: maximum consecutive cycles a fetch request is denied before a forced grant (guard build only).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held high until granted.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  fetch data valid (registered).
- `if_rdata`  out  DATA_W  fetch read data.
- `d_req`  in  1  data request; held high until granted.
- `d_we`  in  1  1 = store, 0 = load.
- `d_be`  in  DATA_W/8  store byte enables.
- `d_addr`  in  ADDR_W  data word address.
- `d_wdata`  in  DATA_W  store data.
- `d_gnt`  out  1  data access accepted this cycle (combinational).
- `d_rvalid`  out  1  load data valid (registered; never asserted for stores).
- `d_rdata`  out  DATA_W  load read data.
- `mem_en`  out  1  memory access this cycle.
- `mem_we`  out  1  memory write strobe.
- `mem_be`  out  DATA_W/8  memory byte enables.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read issue.

## Operation
- Arbitration is combinational each cycle:
  - `d_req` only → data granted.
  - `if_req` only → fetch granted.
  - Both → data granted, unless the guard forces fetch.
  - Neither → `mem_en`=0.
- Exactly one of `if_gnt` and `d_gnt` is high when `mem_en`=1. Both are low when `mem_en`=0, and both are low while `rst`=0.
- `mem_*` signals mirror the granted requester. For a fetch grant: `mem_we`=0 and `mem_be`=all ones.
- Response tracker (registered `rsp_valid`, `rsp_owner`):
  - Set on any read grant.
  - Cleared the next cycle unless another read is granted.
- `if_rvalid` = `rsp_valid` and owner is fetch. `d_rvalid` = `rsp_valid` and owner is data.
- `if_rdata` and `d_rdata` both carry `mem_rdata` directly. Each is qualified only by its own rvalid.
- Wait counter (`wait_cnt`, width clog2(MAX_WAIT+1)):
  - Increments each cycle `if_req`=1 and `if_gnt`=0, saturating at `MAX_WAIT`.
  - Clears on `if_gnt` or when `if_req`=0.
- Reset (asynchronous, `rst`=0):
  - `rsp_valid`=0, `rsp_owner`=fetch, `wait_cnt`=0.
  - Therefore `if_rvalid`=`d_rvalid`=0 and `mem_en`=0.
  - A read in flight at reset assertion produces no rvalid after release.

## Timing
- Grant: same cycle as the request, zero added latency.
- Read data: rvalid exactly one cycle after the grant. Fully pipelined, so back-to-back reads from either or both owners give one response per cycle, in issue order.
- Store: the memory updates at the grant-cycle edge. A load of the same address granted the next cycle returns the new data.
- Requesters must hold address and data stable while req=1 and gnt=0. They may change them the cycle after gnt.
- Under a continuous `d_req`, fetch is granted at most once every `MAX_WAIT`+1 cycles (guard build). Otherwise it waits indefinitely.

## Configuration
- `ARB_STARVE_GUARD_EN`:
  - Defined: when `wait_cnt`==`MAX_WAIT` and `if_req`=1, fetch wins over `d_req` for that cycle, and data stalls (`d_gnt`=0).
  - Undefined: the counter and `MAX_WAIT` logic are removed, and fixed data priority is absolute.

## Test plan
- Reset with `d_req`=`if_req`=1 and `rst`=0 → `mem_en`, both gnts and both rvalids are 0. Release, next cycle → `d_gnt`=1.
- Fetch-only reads of addr 0..3 holding words 0x6C6C6548, 0x6F77206F, 0x21646C72, 0x2C657942 → `if_gnt` every cycle, `if_rvalid` cycles 1–4 with matching data, `d_rvalid`=0 throughout.
- Simultaneous `if_req` (addr 5) and `d_req` load (addr 3) → `d_gnt`=1 and `if_gnt`=0 in cycle 0. Next cycle: `d_rvalid`=1 with `d_rdata`=0x2C657942, and fetch granted.
- Store 0xDEADBEEF with `d_be`=4'b0011 to addr 2 (old 0x21646C72), then load addr 2 the next cycle → `d_rvalid` data = 0x2164BEEF, and no `d_rvalid` for the store.
- Guard build, `d_req` held continuously, `if_req`=1 → `if_gnt` pulses exactly every 5th cycle (`MAX_WAIT`=4). Without the macro, `if_gnt` stays 0 for 20 cycles.
- Load granted, then `rst` asserted before the next edge → no `d_rvalid` appears after reset release.
